mem_port_arbiter: RTL

//  Shares one SRAM-like memory bus between the fetch port (pcF/instrF) and the
//  MEM-stage data port (aluoutM/writedataM/readdataM) of the mips core.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, MEM-stage data port and SRAM-like bus of the shared memory port.
// The slave modport is the arbiter; master is the core plus memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_done;
    logic              inst_stall;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_done;
    logic              data_stall;

    logic              flush;

    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        input  flush,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_rdata, inst_done, inst_stall,
        output data_rdata, data_done, data_stall,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        output flush,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_rdata, inst_done, inst_stall,
        input  data_rdata, data_done, data_stall,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus between fetch and MEM-stage data accesses,
// sequencing address then data phase and producing done/stall terms.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  mp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_D_REQ,
        S_D_WAIT,
        S_I_REQ,
        S_I_WAIT
    } state_t;

    state_t            r_state;
    logic              r_drop;
    logic              r_bus_req;
    logic              r_bus_wr;
    logic [1:0]        r_bus_size;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_inst_rdata;
    logic [DATA_W-1:0] r_data_rdata;
    logic              r_inst_done;
    logic              r_data_done;

    logic              w_d_elig;
    logic              w_i_elig;
    logic [1:0]        w_d_size;
    logic              w_drop;

    // A requester still showing done is not re-granted in that cycle
    assign w_d_elig = mp.data_req & ~r_data_done;
    assign w_i_elig = mp.inst_req & ~r_inst_done;
    assign w_d_size = (mp.data_size == 2'd3) ? 2'd2 : mp.data_size;
    assign w_drop   = r_drop | mp.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_drop       <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_wr     <= 1'b0;
            r_bus_size   <= 2'd0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_d_elig) begin
                        r_state     <= S_D_REQ;
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= mp.data_wr;
                        r_bus_size  <= w_d_size;
                        r_bus_addr  <= mp.data_addr;
                        r_bus_wdata <= mp.data_wdata;
                    end else if (w_i_elig) begin
                        r_state     <= S_I_REQ;
                        r_drop      <= 1'b0;
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= 1'b0;
                        r_bus_size  <= 2'd2;
                        r_bus_addr  <= mp.inst_addr;
                        r_bus_wdata <= '0;
                    end
                end
                S_D_REQ: begin
                    if (mp.bus_addr_ok) begin
                        r_state   <= S_D_WAIT;
                        r_bus_req <= 1'b0;
                    end
                end
                S_D_WAIT: begin
                    if (mp.bus_data_ok) begin
                        r_state      <= S_IDLE;
                        r_data_rdata <= mp.bus_rdata;
                        r_data_done  <= 1'b1;
                    end
                end
                S_I_REQ: begin
                    if (mp.flush) r_drop <= 1'b1;
                    if (mp.bus_addr_ok) begin
                        r_state   <= S_I_WAIT;
                        r_bus_req <= 1'b0;
                    end
                end
                S_I_WAIT: begin
                    // A flush landing with data_ok still cancels this fetch
                    if (mp.bus_data_ok) begin
                        r_state <= S_IDLE;
                        r_drop  <= 1'b0;
                        if (!w_drop) begin
                            r_inst_rdata <= mp.bus_rdata;
                            r_inst_done  <= 1'b1;
                        end
                    end else if (mp.flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mp.bus_req    = r_bus_req;
    assign mp.bus_wr     = r_bus_wr;
    assign mp.bus_size   = r_bus_size;
    assign mp.bus_addr   = r_bus_addr;
    assign mp.bus_wdata  = r_bus_wdata;
    assign mp.inst_rdata = r_inst_rdata;
    assign mp.data_rdata = r_data_rdata;
    assign mp.inst_done  = r_inst_done;
    assign mp.data_done  = r_data_done;
    assign mp.inst_stall = mp.inst_req & ~r_inst_done;
    assign mp.data_stall = mp.data_req & ~r_data_done;

endmodule
